// File: rtl/nibble_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nsa_pkg
// Brief    : Shared constants, state encoding and index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_ADD  = S_ADD,
        ST_DONE = S_DONE
    } state_t;

    // Bits needed to count 0..n-1; never less than one.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl_if
// Brief    : Request/result bundle for the serial adder; ovf with NSA_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_add_ctrl_if
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) ();
    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef NSA_OVERFLOW_EN
    logic         ovf;

    modport master (output start, a, b, c_in, input busy, done, sum, c_out, ovf);
    modport slave  (input start, a, b, c_in, output busy, done, sum, c_out, ovf);
`else
    modport master (output start, a, b, c_in, input busy, done, sum, c_out);
    modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_nibble_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_adder
// Brief    : Combinational 4-bit ripple-carry adder, also exposing carry into bit 3.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_adder
    import nsa_pkg::*;
(
    input  wire logic [NIBBLE_W-1:0] a,
    input  wire logic [NIBBLE_W-1:0] b,
    input  wire logic                c_in,
    output logic      [NIBBLE_W-1:0] s,
    output logic                     c_out,
    output logic                     c3
);
    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign c_out = w_c[NIBBLE_W];
    assign c3    = w_c[NIBBLE_W-1];
endmodule
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : Wide add sequenced one nibble per clock through a single 4-bit adder.
//            Optional signed-overflow flag with NSA_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_idx;
    logic                  r_carry;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic [W-1:0]          r_sum;
    logic                  r_c_out;
    logic [NIBBLE_W-1:0]   w_a_nib;
    logic [NIBBLE_W-1:0]   w_b_nib;
    logic [NIBBLE_W-1:0]   w_s;
    logic                  w_co;
    logic                  w_c3;
    logic                  w_last;

    assign w_last = (r_idx == IW'(NIBBLES - 1));

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_adder u_adder (
        .a     (w_a_nib),
        .b     (w_b_nib),
        .c_in  (r_carry),
        .s     (w_s),
        .c_out (w_co),
        .c3    (w_c3)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_ADD;
            ST_ADD:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE:                w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.c_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_c_out <= 1'b0;
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IW'(i)) r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_s;
                    end
                    r_carry <= w_co;
                    if (w_last) r_c_out <= w_co;
                    else        r_idx   <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef NSA_OVERFLOW_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_ADD && w_last) begin
            r_ovf <= w_c3 ^ w_co;
        end
    end

    assign bus.ovf = r_ovf;
`else
    logic w_unused_c3;
    assign w_unused_c3 = w_c3;
`endif

    assign bus.busy  = (r_state == ST_ADD);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.sum   = r_sum;
    assign bus.c_out = r_c_out;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_add_ctrl
// Brief    : Directed self-checking bench for nibble_serial_add_ctrl (NIBBLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;
    localparam int NIBBLES = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One full operation; operands are scrambled right after acceptance.
    task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic [15:0] es, input logic eco,
                           input logic eov);
        int busy_cnt;
        int cyc;
        @(posedge clock); #1;
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.c_in = ci;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.c_in = ~ci;
        busy_cnt = 0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, ".busy_cycles"}, busy_cnt, NIBBLES);
        check({tag, ".done"}, bus.done, 1'b1);
        check({tag, ".sum"}, bus.sum, es);
        check({tag, ".c_out"}, bus.c_out, eco);
`ifdef NSA_OVERFLOW_EN
        check({tag, ".ovf"}, bus.ovf, eov);
`endif
        @(posedge clock); #1;
        check({tag, ".done_fall"}, bus.done, 1'b0);
        check({tag, ".sum_hold"}, bus.sum, es);
    endtask

    initial begin
        int done_cnt;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        #1;
        check("rst.busy", bus.busy, 1'b0);
        check("rst.done", bus.done, 1'b0);
        check("rst.sum", bus.sum, 16'h0000);
        check("rst.c_out", bus.c_out, 1'b0);
        @(posedge clock); @(posedge clock); #1;
        resetn = 1'b1;

        run_add("inc",    16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0);
        run_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_add("cin",    16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0);
        run_add("allf",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Second start during busy must be ignored.
        @(posedge clock); #1;
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h1111; bus.c_in = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("ign.busy", bus.busy, 1'b1);
        bus.start = 1'b1; bus.a = 16'hAAAA;
        @(posedge clock); #1;
        bus.start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                check("ign.sum", bus.sum, 16'h2222);
            end
            @(posedge clock); #1;
        end
        check("ign.done_count", done_cnt, 1);

        // Reset mid-operation after two ADD cycles.
        bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0001; bus.c_in = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("mid.busy_before", bus.busy, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("mid.busy", bus.busy, 1'b0);
        check("mid.sum", bus.sum, 16'h0000);
        check("mid.c_out", bus.c_out, 1'b0);
        @(posedge clock); #1;
        resetn = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            @(posedge clock); #1;
        end
        check("mid.no_done", done_cnt, 0);
        run_add("after_rst", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);

`ifdef NSA_OVERFLOW_EN
        run_add("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_add("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_add("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
